// File: rtl/acumulador_pontuacao.sv
// Per-game score accumulator fed by the round grader.
// It keeps the running total, round count, last score and best score, and flags end of game.
module acumulador_pontuacao #(
   parameter int RODADAS       = 5,
   parameter int LARGURA_TOTAL = 7
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     iniciar,
   input  logic                     registra,
   input  logic [3:0]               nota,
   output logic [LARGURA_TOTAL-1:0] total,
   output logic [3:0]               rodada,
   output logic [3:0]               ultima,
   output logic [3:0]               melhor,
   output logic                     aceito,
   output logic                     invalida,
   output logic                     pronto,
   output logic                     fim
);

   typedef enum logic [1:0] {OCIOSO, JOGANDO, FIM} estado_t;

   localparam logic [3:0]               RODADAS_4 = 4'(RODADAS);
   localparam logic [LARGURA_TOTAL-1:0] TOTAL_MAX = {LARGURA_TOTAL{1'b1}};

   estado_t                  r_estado;
   logic [LARGURA_TOTAL-1:0] r_total;
   logic [3:0]               r_rodada, r_ultima, r_melhor;
   logic                     r_aceito, r_invalida, r_pronto, r_fim;

   logic                     w_valida;
   logic [3:0]               w_pontos;
   logic [LARGURA_TOTAL:0]   w_soma;
   logic [3:0]               w_prox_rodada;

   assign w_valida      = (nota >= 4'd1) && (nota <= 4'd10);
   assign w_pontos      = w_valida ? nota : 4'd0;
   // The extra carry bit exposes overflow, so the total can saturate instead of wrapping.
   assign w_soma        = {1'b0, r_total} + (LARGURA_TOTAL+1)'(w_pontos);
   assign w_prox_rodada = r_rodada + 4'd1;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_estado   <= OCIOSO;
         r_total    <= '0;
         r_rodada   <= '0;
         r_ultima   <= '0;
         r_melhor   <= '0;
         r_aceito   <= 1'b0;
         r_invalida <= 1'b0;
         r_pronto   <= 1'b1;
         r_fim      <= 1'b0;
      end else begin
         r_aceito   <= 1'b0;
         r_invalida <= 1'b0;
         if (iniciar) begin
            // Starting or restarting a game from any state clears the game and discards the current score.
            r_estado <= JOGANDO;
            r_total  <= '0;
            r_rodada <= '0;
            r_ultima <= '0;
            r_melhor <= '0;
            r_pronto <= 1'b0;
            r_fim    <= 1'b0;
         end else begin
            case (r_estado)
               JOGANDO: begin
                  if (registra) begin
                     r_total    <= w_soma[LARGURA_TOTAL] ? TOTAL_MAX : w_soma[LARGURA_TOTAL-1:0];
                     r_rodada   <= w_prox_rodada;
                     r_ultima   <= w_pontos;
                     r_melhor   <= (w_pontos > r_melhor) ? w_pontos : r_melhor;
                     r_aceito   <= 1'b1;
                     r_invalida <= ~w_valida;
                     if (w_prox_rodada == RODADAS_4) begin
                        r_estado <= FIM;
                        r_fim    <= 1'b1;
                     end
                  end
               end
               OCIOSO:  r_estado <= OCIOSO;
               FIM:     r_estado <= FIM;
               default: begin
                  r_estado <= OCIOSO;
                  r_pronto <= 1'b1;
                  r_fim    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign total    = r_total;
   assign rodada   = r_rodada;
   assign ultima   = r_ultima;
   assign melhor   = r_melhor;
   assign aceito   = r_aceito;
   assign invalida = r_invalida;
   assign pronto   = r_pronto;
   assign fim      = r_fim;

endmodule

// File: doc/acumulador_pontuacao.md
# acumulador_pontuacao

Score accumulator placed directly downstream of the per-round grader (nota = 10 − |ideal − sensor|, valid range 1–10, invalid sentinel 11). Over a game of a fixed number of rounds it:
- accepts one 4-bit nota per round on a strobe;
- keeps the running total, round count, last nota and best nota;
- flags end of game.

The display and top-level control logic read its outputs.

## Interface
Parameters:
- RODADAS, 5, rounds per game; legal range 1–15.
- LARGURA_TOTAL, 7, width of total; must satisfy 2^LARGURA_TOTAL − 1 ≥ 10·RODADAS.

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- iniciar  in  1  start/restart game; sampled every cycle.
- registra  in  1  nota valid strobe; each high cycle = one round.
- nota  in  4  grader output; 1–10 valid, any other value invalid.
- total  out  LARGURA_TOTAL  sum of points in current game.
- rodada  out  4  rounds completed in current game.
- ultima  out  4  points credited in most recent round.
- melhor  out  4  maximum points credited in any round of current game.
- aceito  out  1  one-cycle pulse: a round was credited.
- invalida  out  1  one-cycle pulse alongside aceito when the credited nota was invalid.
- pronto  out  1  high in OCIOSO.
- fim  out  1  high in FIM.

## Operation
- States:
  - OCIOSO: after reset.
  - JOGANDO: game in progress.
  - FIM: RODADAS rounds credited.
- Reset (reset=1 at an edge): state OCIOSO; total=0, rodada=0, ultima=0, melhor=0, aceito=0, invalida=0, fim=0, pronto=1. Reset overrides all other inputs.
- OCIOSO:
  - iniciar=1 → JOGANDO; clear total, rodada, ultima, melhor.
  - registra ignored.
- JOGANDO, with registra=1 and iniciar=0:
  - pontos = nota if 1 ≤ nota ≤ 10, else 0.
  - total += pontos, saturating at 2^LARGURA_TOTAL − 1.
  - rodada += 1; ultima = pontos; melhor = max(melhor, pontos).
  - aceito=1; invalida=1 iff nota was outside 1–10.
  - If the new rodada = RODADAS → FIM on the same edge.
- JOGANDO, with iniciar=1 (with or without registra): restart. Clear counters, stay in JOGANDO, discard the nota, aceito=0.
- FIM:
  - All outputs hold; registra ignored, no aceito.
  - iniciar=1 → JOGANDO with clear.
- Consecutive registra cycles are each credited as separate rounds; no edge detection.

## Timing
- All outputs are registered.
- Latency: registra sampled at edge N → updated total/rodada/ultima/melhor and aceito visible after edge N; aceito falls after edge N+1 unless registra is still high.
- pronto and fim change on the same edge as the state transition.
- Final round: the edge crediting round RODADAS also raises fim and updates total. If registra is high on the following cycle, that cycle is ignored.
- iniciar to first creditable cycle is 1 cycle: from OCIOSO, registra is honoured starting the cycle after the iniciar edge.
- Reset mid-game discards all progress within one edge.

## Test plan
- Reset then idle: after reset, pronto=1, fim=0, all counters 0. Then registra=1 with nota=7 → no change, aceito stays 0.
- Full game, RODADAS=5: iniciar; notas 10,7,3,9,5 on consecutive registra cycles → aceito high 5 cycles; total=34, rodada=5, ultima=5, melhor=10; fim=1 after the 5th edge; a 6th registra is ignored.
- Invalid nota: in JOGANDO, nota=11 with registra → pontos 0, aceito=1, invalida=1, total unchanged, rodada+1, ultima=0. Same for nota=0.
- Simultaneous iniciar+registra mid-game (total=17, rodada=2) → total=0, rodada=0, aceito=0, still JOGANDO.
- Restart from FIM: iniciar → pronto=0, fim=0, counters cleared. Then one registra with nota=8 → total=8, rodada=1.
- Saturation, parameters RODADAS=15, LARGURA_TOTAL=7: fifteen notas of 10 → total=127 (saturated, not 150 mod 128); fim=1.
